regfile_pipe: RTL and testbench
===============================

REGFILE_PIPE -- requirements
Module: regfile_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers, a power of two and at least 2; ADDR_W = clog2(DEPTH).
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports, between 1 and 4.
REQ-004 SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads as 0, ignores writes and is never busy.
REQ-005 SHALL have parameter BYPASS, default 1; when 1, a same-cycle write forwards to matching read ports.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock, all state on rising edge.
REQ-007 SHALL have rst  in  1  asynchronous active-low reset.
REQ-008 SHALL have Clr  in  1  synchronous soft-clear request.
REQ-009 SHALL have WrEn  in  1  write enable.
REQ-010 SHALL have WrReg  in  ADDR_W  write address.
REQ-011 SHALL have WrData  in  DATA_W  write data.
REQ-012 SHALL have IssEn  in  1  issue enable; marks IssReg busy.
REQ-013 SHALL have IssReg  in  ADDR_W  destination being issued.
REQ-014 SHALL have RdReg  in  NUM_RD*ADDR_W  read addresses, port k in bits [k*ADDR_W +: ADDR_W].
REQ-015 SHALL have RdData  out  NUM_RD*DATA_W  read data, packed in the same way.
REQ-016 SHALL have RdBusy  out  NUM_RD  per-port busy flag for the addressed register.
REQ-017 SHALL have Ready  out  1  high when initialisation is complete.

Function
REQ-018 SHALL implement two states, INIT and RUN.
REQ-019 In INIT, SHALL zero the entry at counter index clr_idx each cycle and clear its busy bit; clr_idx counts 0 to DEPTH-1.
REQ-020 After zeroing entry DEPTH-1, SHALL enter RUN on the next edge; INIT therefore lasts exactly DEPTH cycles.
REQ-021 In INIT, SHALL drive Ready=0, all RdData=0 and all RdBusy=0, and SHALL ignore WrEn and IssEn.
REQ-022 In RUN, Clr=1 SHALL return to INIT with clr_idx=0 on the next edge; Clr in INIT SHALL restart clr_idx at 0.
REQ-023 In RUN, WrEn=1 SHALL store WrData into WrReg at the edge and clear busy[WrReg], except register 0 when ZERO_REG=1.
REQ-024 In RUN, IssEn=1 SHALL set busy[IssReg], except register 0 when ZERO_REG=1.
REQ-025 If IssEn and WrEn target the same register in one cycle, SHALL store the data and leave busy set (issue wins).
REQ-026 Reads SHALL be combinational from RdReg; with BYPASS=0, a write becomes visible the cycle after its edge.
REQ-027 With BYPASS=1, WrEn=1 and RdReg[k]==WrReg (not a suppressed register 0) SHALL return WrData on port k and RdBusy[k]=0 in the same cycle.
REQ-028 Multiple read ports addressing the same register SHALL all return identical data and busy.
REQ-029 Register 0 with ZERO_REG=1 SHALL read 0 and not busy regardless of bypass.

Reset
REQ-030 Asserting rst low SHALL immediately set state=INIT, clr_idx=0, Ready=0 and all busy bits to 0; storage contents need not reset.
REQ-031 After rst deasserts, SHALL complete a full DEPTH-cycle INIT before Ready=1; reset asserted during INIT SHALL restart it.

Structure
REQ-032 SHALL place the state enum (INIT, RUN) and the default parameter constants in shared package regfile_pkg.
REQ-033 SHALL implement the init counter and state machine as sub-module regfile_init_seq, which outputs clr_idx, the INIT zero-write strobe and Ready.
REQ-034 Storage SHALL have no reset and a single write port, so it can be mapped to memory.

Verification
REQ-035 Reset, then rst high: Ready=0 for exactly 32 cycles and rises on cycle 33; all RdData=0 meanwhile.
REQ-036 Write 0xDEADBEEF to r5, then read r5 on both ports the next cycle: both return 0xDEADBEEF; write to r0, then read r0: returns 0.
REQ-037 BYPASS=1, same cycle WrEn r7=0x12345678 and RdReg0=7: RdData0=0x12345678; with BYPASS=0 it returns the old value.
REQ-038 IssEn r9, then read r9: RdBusy=1; WrEn r9 clears it; simultaneous IssEn and WrEn on r9: data stored and RdBusy stays 1.
REQ-039 Clr at cycle 100 in RUN: Ready=0 for 32 cycles, then r5 reads 0 and no register is busy.
REQ-040 rst pulsed low at INIT cycle 10: Ready stays 0 for a full 32 cycles after release; a WrEn during INIT has no effect.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default parameters for the pipelined register file.
package regfile_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_DEPTH    = 32;
    localparam int unsigned DEF_NUM_RD   = 2;
    localparam int unsigned DEF_ZERO_REG = 1;
    localparam int unsigned DEF_BYPASS   = 1;

endpackage

// File: rtl/regfile_init_seq.sv
// Init/run sequencer: sweeps clr_idx over every entry after reset or a
// soft clear, then raises ready.
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter  int unsigned DEPTH  = DEF_DEPTH,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic [ADDR_W-1:0] clr_idx,
    output logic              clr_we,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_e            state;
    state_e            state_nxt;
    logic [ADDR_W-1:0] idx_nxt;

    always_comb begin
        state_nxt = state;
        idx_nxt   = clr_idx;
        unique case (state)
            ST_INIT: begin
                if (clr) begin
                    idx_nxt = '0;
                end else if (clr_idx == LAST_IDX) begin
                    state_nxt = ST_RUN;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = clr_idx + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                if (clr) begin
                    state_nxt = ST_INIT;
                    idx_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_INIT;
                idx_nxt   = '0;
            end
        endcase
    end

    // Strobe and ready are registered copies of the next-state decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_INIT;
            clr_idx <= '0;
            clr_we  <= 1'b1;
            ready   <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_idx <= idx_nxt;
            clr_we  <= (state_nxt == ST_INIT);
            ready   <= (state_nxt == ST_RUN);
        end
    end

endmodule

// File: rtl/regfile_pipe.sv
// Register file with per-register busy scoreboard, optional write bypass
// and a hardwired-zero register 0; contents are swept to zero on init.
module regfile_pipe
    import regfile_pkg::*;
#(
    parameter  int unsigned DATA_W   = DEF_DATA_W,
    parameter  int unsigned DEPTH    = DEF_DEPTH,
    parameter  int unsigned NUM_RD   = DEF_NUM_RD,
    parameter  int unsigned ZERO_REG = DEF_ZERO_REG,
    parameter  int unsigned BYPASS   = DEF_BYPASS,
    localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     Clr,
    input  logic                     WrEn,
    input  logic [ADDR_W-1:0]        WrReg,
    input  logic [DATA_W-1:0]        WrData,
    input  logic                     IssEn,
    input  logic [ADDR_W-1:0]        IssReg,
    input  logic [NUM_RD*ADDR_W-1:0] RdReg,
    output logic [NUM_RD*DATA_W-1:0] RdData,
    output logic [NUM_RD-1:0]        RdBusy,
    output logic                     Ready
);

    localparam bit ZR = (ZERO_REG != 0);
    localparam bit BP = (BYPASS != 0);

    logic [ADDR_W-1:0] clr_idx;
    logic              clr_we;
    logic              ready;

    regfile_init_seq #(
        .DEPTH (DEPTH)
    ) u_init_seq (
        .clk     (clk),
        .rst     (rst),
        .clr     (Clr),
        .clr_idx (clr_idx),
        .clr_we  (clr_we),
        .ready   (ready)
    );

    assign Ready = ready;

    // Register 0 is suppressed for both writes and issues when hardwired.
    logic wr_ok;
    logic iss_ok;
    assign wr_ok  = ready && WrEn  && !(ZR && (WrReg  == '0));
    assign iss_ok = ready && IssEn && !(ZR && (IssReg == '0));

    // Single write port shared between the init sweep and normal writes.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem [DEPTH];

    assign mem_we = clr_we | wr_ok;
    assign mem_wa = clr_we ? clr_idx : WrReg;
    assign mem_wd = clr_we ? '0 : WrData;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Issue is applied last so it wins over a same-cycle write.
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy;
        if (clr_we) begin
            busy_nxt[clr_idx] = 1'b0;
        end
        if (wr_ok) begin
            busy_nxt[WrReg] = 1'b0;
        end
        if (iss_ok) begin
            busy_nxt[IssReg] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              zero_hit;
        logic              byp_hit;
        logic [DATA_W-1:0] data;
        logic              bsy;

        assign addr     = RdReg[k*ADDR_W +: ADDR_W];
        assign zero_hit = ZR && (addr == '0);
        assign byp_hit  = BP && wr_ok && (addr == WrReg);

        always_comb begin
            data = '0;
            bsy  = 1'b0;
            if (ready && !zero_hit) begin
                if (byp_hit) begin
                    data = WrData;
                end else begin
                    data = mem[addr];
                    bsy  = busy[addr];
                end
            end
        end

        assign RdData[k*DATA_W +: DATA_W] = data;
        assign RdBusy[k]                  = bsy;
    end

endmodule

// File: tb/tb_regfile_pipe.sv
// Randomized bench for regfile_pipe with a bypass and a non-bypass instance
// compared against an array-based reference model.
module tb_regfile_pipe;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NRD   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              Clr;
    logic              WrEn;
    logic [AW-1:0]     WrReg;
    logic [DW-1:0]     WrData;
    logic              IssEn;
    logic [AW-1:0]     IssReg;
    logic [NRD*AW-1:0] RdReg;

    logic [NRD*DW-1:0] rd_data_b, rd_data_n;
    logic [NRD-1:0]    rd_busy_b, rd_busy_n;
    logic              ready_b, ready_n;

    regfile_pipe dut (
        .clk(clk), .rst(rst), .Clr(Clr), .WrEn(WrEn), .WrReg(WrReg), .WrData(WrData),
        .IssEn(IssEn), .IssReg(IssReg), .RdReg(RdReg),
        .RdData(rd_data_b), .RdBusy(rd_busy_b), .Ready(ready_b)
    );

    regfile_pipe #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .Clr(Clr), .WrEn(WrEn), .WrReg(WrReg), .WrData(WrData),
        .IssEn(IssEn), .IssReg(IssReg), .RdReg(RdReg),
        .RdData(rd_data_n), .RdBusy(rd_busy_n), .Ready(ready_n)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: architectural contents, busy flags, INIT cycles left.
    logic [DW-1:0] m_reg  [DEPTH];
    bit            m_busy [DEPTH];
    int            m_init_left;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] rd_addr(input int k);
        return RdReg[k*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
        if (m_init_left != 0 || a == '0) return '0;
        if (byp && WrEn && WrReg == a) return WrData;
        return m_reg[a];
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a, input bit byp);
        if (m_init_left != 0 || a == '0) return 1'b0;
        if (byp && WrEn && WrReg == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic check_outputs();
        logic [AW-1:0] a;
        check("ready_byp",   64'(ready_b), 64'(m_init_left == 0));
        check("ready_nobyp", 64'(ready_n), 64'(m_init_left == 0));
        for (int k = 0; k < NRD; k++) begin
            a = rd_addr(k);
            check($sformatf("byp_data%0d_r%0d", k, a),   64'(rd_data_b[k*DW +: DW]), 64'(exp_data(a, 1'b1)));
            check($sformatf("nobyp_data%0d_r%0d", k, a), 64'(rd_data_n[k*DW +: DW]), 64'(exp_data(a, 1'b0)));
            check($sformatf("byp_busy%0d_r%0d", k, a),   64'(rd_busy_b[k]), 64'(exp_busy(a, 1'b1)));
            check($sformatf("nobyp_busy%0d_r%0d", k, a), 64'(rd_busy_n[k]), 64'(exp_busy(a, 1'b0)));
        end
    endtask

    task automatic model_edge();
        if (!rst) return;
        if (m_init_left > 0) begin
            if (Clr) begin
                m_init_left = DEPTH;
            end else begin
                m_init_left--;
                if (m_init_left == 0) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        m_reg[i]  = '0;
                        m_busy[i] = 1'b0;
                    end
                end
            end
        end else if (Clr) begin
            m_init_left = DEPTH;
        end else begin
            if (WrEn && WrReg != '0) begin
                m_reg[WrReg]  = WrData;
                m_busy[WrReg] = 1'b0;
            end
            if (IssEn && IssReg != '0) m_busy[IssReg] = 1'b1;
        end
    endtask

    // Inputs are held from just after one rising edge to just after the next.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic idle();
        Clr  = 1'b0;
        WrEn = 1'b0;
        IssEn = 1'b0;
    endtask

    task automatic assert_reset();
        rst = 1'b0;
        m_init_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
    endtask

    task automatic init_window(input string tag);
        for (int i = 1; i <= DEPTH; i++) begin
            cycle();
            check(tag, 64'(ready_b), 64'(i == DEPTH));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        WrReg = '0; IssReg = '0; WrData = '0; RdReg = {5'd17, 5'd3};
        for (int i = 0; i < DEPTH; i++) m_reg[i] = '0;
        assert_reset();
        repeat (2) @(posedge clk);
        #1;
        check("ready_in_reset", 64'(ready_b), 64'd0);
        check("busy_in_reset", 64'(rd_busy_b), 64'd0);
        rst = 1'b1;
        init_window("init_ready");

        // Write r5 and read it on both ports; r0 ignores writes.
        WrEn = 1'b1; WrReg = 5'd5; WrData = 32'hDEADBEEF;
        cycle();
        idle(); RdReg = {5'd5, 5'd5}; #1;
        check("r5_port0", 64'(rd_data_b[0 +: DW]),  64'h0000_0000_DEAD_BEEF);
        check("r5_port1", 64'(rd_data_b[DW +: DW]), 64'h0000_0000_DEAD_BEEF);
        WrEn = 1'b1; WrReg = 5'd0; WrData = 32'hFFFF0000;
        cycle();
        idle(); RdReg = '0; #1;
        check("r0_port0", 64'(rd_data_b[0 +: DW]),  64'd0);
        check("r0_port1", 64'(rd_data_b[DW +: DW]), 64'd0);

        // Same-cycle bypass versus old value.
        WrEn = 1'b1; WrReg = 5'd7; WrData = 32'hAAAA5555;
        cycle();
        WrData = 32'h12345678; RdReg = {5'd0, 5'd7}; #1;
        check("r7_bypass",   64'(rd_data_b[0 +: DW]), 64'h0000_0000_1234_5678);
        check("r7_nobypass", 64'(rd_data_n[0 +: DW]), 64'h0000_0000_AAAA_5555);
        cycle();
        idle(); #1;
        check("r7_nobypass_next", 64'(rd_data_n[0 +: DW]), 64'h0000_0000_1234_5678);

        // Busy scoreboard on r9.
        IssEn = 1'b1; IssReg = 5'd9;
        cycle();
        idle(); RdReg = {5'd9, 5'd9}; #1;
        check("r9_busy_after_issue", 64'(rd_busy_b), 64'd3);
        WrEn = 1'b1; WrReg = 5'd9; WrData = 32'h0BADF00D; #1;
        check("r9_busy_bypass_write", 64'(rd_busy_b), 64'd0);
        check("r9_busy_nobypass_write", 64'(rd_busy_n), 64'd3);
        cycle();
        idle(); #1;
        check("r9_busy_after_write", 64'(rd_busy_b), 64'd0);
        IssEn = 1'b1; IssReg = 5'd9; WrEn = 1'b1; WrReg = 5'd9; WrData = 32'hCAFEF00D;
        cycle();
        idle(); #1;
        check("r9_busy_issue_wins", 64'(rd_busy_n), 64'd3);
        check("r9_data_issue_wins", 64'(rd_data_n[DW +: DW]), 64'h0000_0000_CAFE_F00D);

        // Soft clear in RUN at cycle 100.
        while (cyc < 100) cycle();
        Clr = 1'b1;
        cycle();
        Clr = 1'b0;
        init_window("clr_ready");
        for (int a = 0; a < DEPTH; a++) begin
            RdReg = {AW'(a), AW'(a)}; #1;
            check($sformatf("clr_data_r%0d", a), 64'(rd_data_b[0 +: DW]), 64'd0);
            check($sformatf("clr_busy_r%0d", a), 64'(rd_busy_b), 64'd0);
        end

        // Randomized traffic with occasional soft clears.
        repeat (1500) begin
            WrEn   = 1'($urandom_range(0, 1));
            WrReg  = AW'($urandom_range(0, DEPTH - 1));
            WrData = $urandom;
            IssEn  = ($urandom_range(0, 3) == 0);
            IssReg = ($urandom_range(0, 2) == 0) ? WrReg : AW'($urandom_range(0, DEPTH - 1));
            for (int k = 0; k < NRD; k++) begin
                RdReg[k*AW +: AW] = ($urandom_range(0, 2) == 0) ? WrReg
                                   : ($urandom_range(0, 2) == 0) ? IssReg
                                   : AW'($urandom_range(0, DEPTH - 1));
            end
            Clr = ($urandom_range(0, 299) == 0);
            cycle();
        end
        idle();

        // Reset pulse at INIT cycle 10, with writes attempted during INIT.
        assert_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        WrEn = 1'b1; WrReg = 5'd5; WrData = 32'h55AA55AA;
        IssEn = 1'b1; IssReg = 5'd6;
        RdReg = {5'd6, 5'd5};
        repeat (10) cycle();
        assert_reset(); #2;
        check("ready_mid_init_rst", 64'(ready_b), 64'd0);
        rst = 1'b1;
        init_window("reinit_ready");
        idle(); #1;
        check("reinit_r5_data", 64'(rd_data_b[0 +: DW]), 64'd0);
        check("reinit_r6_busy", 64'(rd_busy_b), 64'd0);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
